serial_paralelo_param: RTL and testbench

Parametrised serial-to-parallel converter with comma-based word alignment and lock/loss-of-lock tracking. It receives one bit per clock on the bit-rate clock and searches every bit offset for the COMMA symbol. It declares lock after LOCK_COUNT consecutive aligned commas, then emits one parallel word per WIDTH bits with a valid flag for non-comma words. It is the single-clock, generalised successor of the fixed 8-bit BC-comma deserialiser: it adds a word strobe, arbitrary alignment, selectable bit order and gap-based loss of lock.

---
 rtl/sp_pkg.sv | 14 +
 rtl/sp_shifter.sv | 25 ++
 rtl/serial_paralelo_param.sv | 136 +++++++++++++
 tb/tb_serial_paralelo_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared types and default parameter values for the comma-aligned
// serial-to-parallel converter.
package sp_pkg;

   typedef enum logic [1:0] {
      SEARCH,
      CONFIRM,
      LOCKED
   } state_t;

   localparam logic [7:0] DEF_COMMA      = 8'hBC;
   localparam int         DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/sp_shifter.sv
// Serial input shift register; exposes the next-cycle contents so the
// control logic can compare against the word completed by the current bit.
module sp_shifter #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] nsr
);

   logic [WIDTH-1:0] sr;

   always_comb begin
      if (MSB_FIRST) nsr = {sr[WIDTH-2:0], data_in};
      else           nsr = {data_in, sr[WIDTH-1:1]};
   end

   always_ff @(posedge clk_32f) begin
      if (reset) sr <= '0;
      else       sr <= nsr;
   end

endmodule

// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel converter with comma search, lock confirmation and
// optional loss of lock after a run of comma-free words.
module serial_paralelo_param
   import sp_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
   parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int               UNLOCK_GAP = 0,
   parameter bit               MSB_FIRST  = 1'b1
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             word_stb,
   output logic             active
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int GW = (UNLOCK_GAP > 0) ? $clog2(UNLOCK_GAP + 1) : 1;

   localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);
   localparam logic [CW-1:0] CMAX = CW'(LOCK_COUNT);
   localparam logic [GW-1:0] GMAX = GW'(UNLOCK_GAP);

   logic [WIDTH-1:0] nsr;
   state_t           state, state_n;
   logic [BW-1:0]    bcnt, bcnt_n;
   logic [CW-1:0]    ccnt, ccnt_n, ccnt_inc;
   logic [GW-1:0]    gcnt, gcnt_n, gcnt_inc;
   logic [WIDTH-1:0] data_n;
   logic             valid_n, stb_n, active_n;
   logic             boundary, is_comma;

   sp_shifter #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clk_32f (clk_32f),
      .reset   (reset),
      .data_in (data_in),
      .nsr     (nsr)
   );

   always_comb begin
      state_n  = state;
      bcnt_n   = (bcnt == BMAX) ? '0 : bcnt + 1'b1;
      ccnt_n   = ccnt;
      gcnt_n   = gcnt;
      data_n   = data_out;
      valid_n  = valid_out;
      stb_n    = 1'b0;
      active_n = active;
      boundary = (bcnt == BMAX);
      is_comma = (nsr == COMMA);
      ccnt_inc = (ccnt == CMAX) ? ccnt : ccnt + 1'b1;
      gcnt_inc = (gcnt == GMAX) ? gcnt : gcnt + 1'b1;
      case (state)
         SEARCH: begin
            valid_n = 1'b0;
            // Any bit offset may start a word; a comma fixes the alignment.
            if (is_comma) begin
               bcnt_n = '0;
               ccnt_n = CW'(1);
               gcnt_n = '0;
               if (LOCK_COUNT == 1) begin
                  state_n  = LOCKED;
                  active_n = 1'b1;
               end else begin
                  state_n = CONFIRM;
               end
            end
         end
         CONFIRM: begin
            valid_n = 1'b0;
            if (boundary) begin
               if (is_comma) begin
                  ccnt_n = ccnt_inc;
                  if (ccnt_inc == CMAX) begin
                     state_n  = LOCKED;
                     active_n = 1'b1;
                     gcnt_n   = '0;
                  end
               end else begin
                  state_n = SEARCH;
                  ccnt_n  = '0;
               end
            end
         end
         LOCKED: begin
            if (boundary) begin
               data_n  = nsr;
               stb_n   = 1'b1;
               valid_n = !is_comma;
               gcnt_n  = is_comma ? '0 : gcnt_inc;
               // The word that exhausts the gap is still delivered as valid.
               if ((UNLOCK_GAP > 0) && !is_comma && (gcnt_inc == GMAX)) begin
                  state_n  = SEARCH;
                  active_n = 1'b0;
                  ccnt_n   = '0;
                  gcnt_n   = '0;
               end
            end
         end
         default: begin
            state_n = SEARCH;
         end
      endcase
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state     <= SEARCH;
         bcnt      <= '0;
         ccnt      <= '0;
         gcnt      <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         word_stb  <= 1'b0;
         active    <= 1'b0;
      end else begin
         state     <= state_n;
         bcnt      <= bcnt_n;
         ccnt      <= ccnt_n;
         gcnt      <= gcnt_n;
         data_out  <= data_n;
         valid_out <= valid_n;
         word_stb  <= stb_n;
         active    <= active_n;
      end
   end

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Directed bench for the comma-aligned serial-to-parallel converter with a
// scoreboard of expected words, across three parameterisations.
module tb_serial_paralelo_param;

   typedef struct {
      logic [9:0] d;
      logic       v;
   } exp_t;

   logic clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   // Instance A: defaults. Instance B: UNLOCK_GAP=4. Instance C: 10-bit LSB first.
   logic       rst_a = 1'b1, din_a = 1'b0, vld_a, stb_a, act_a;
   logic [7:0] dout_a;
   logic       rst_b = 1'b1, din_b = 1'b0, vld_b, stb_b, act_b;
   logic [7:0] dout_b;
   logic       rst_c = 1'b1, din_c = 1'b0, vld_c, stb_c, act_c;
   logic [9:0] dout_c;

   serial_paralelo_param u_a (
      .clk_32f (clk_32f), .reset (rst_a), .data_in (din_a),
      .data_out (dout_a), .valid_out (vld_a), .word_stb (stb_a), .active (act_a)
   );

   serial_paralelo_param #(.UNLOCK_GAP(4)) u_b (
      .clk_32f (clk_32f), .reset (rst_b), .data_in (din_b),
      .data_out (dout_b), .valid_out (vld_b), .word_stb (stb_b), .active (act_b)
   );

   serial_paralelo_param #(.WIDTH(10), .COMMA(10'h17C), .MSB_FIRST(1'b0)) u_c (
      .clk_32f (clk_32f), .reset (rst_c), .data_in (din_c),
      .data_out (dout_c), .valid_out (vld_c), .word_stb (stb_c), .active (act_c)
   );

   int         sel = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       exp_q[$];
   logic [9:0] o_data;
   logic       o_vld, o_stb, o_act;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
      end
   endtask

   task automatic sample();
      case (sel)
         0:       begin o_data = {2'b00, dout_a}; o_vld = vld_a; o_stb = stb_a; o_act = act_a; end
         1:       begin o_data = {2'b00, dout_b}; o_vld = vld_b; o_stb = stb_b; o_act = act_b; end
         default: begin o_data = dout_c;          o_vld = vld_c; o_stb = stb_c; o_act = act_c; end
      endcase
   endtask

   task automatic set_rst(input logic r);
      case (sel)
         0:       rst_a = r;
         1:       rst_b = r;
         default: rst_c = r;
      endcase
   endtask

   task automatic step(input logic b);
      @(negedge clk_32f);
      case (sel)
         0:       din_a = b;
         1:       din_b = b;
         default: din_c = b;
      endcase
      @(posedge clk_32f);
      #1;
      sample();
   endtask

   task automatic do_reset();
      @(negedge clk_32f);
      set_rst(1'b1);
      @(posedge clk_32f);
      #1;
      sample();
      chk("rst_data", 32'(o_data), 32'h0);
      chk("rst_vld", 32'(o_vld), 32'h0);
      chk("rst_stb", 32'(o_stb), 32'h0);
      chk("rst_act", 32'(o_act), 32'h0);
      set_rst(1'b0);
   endtask

   // Sends one word in the selected instance's bit order; when a word is
   // expected, its stb must appear exactly on the last bit.
   task automatic send_word(input logic [9:0] w, input bit exp_word, input logic exp_v,
                            input bit act_chk, input logic act_mid, input logic act_last,
                            input bit vld0_first = 1'b0);
      int   width;
      bit   msb;
      exp_t e;
      logic [9:0] wv;
      width = (sel == 2) ? 10 : 8;
      msb   = (sel != 2);
      wv    = w;
      if (exp_word) begin
         e.d = wv;
         e.v = exp_v;
         exp_q.push_back(e);
      end
      for (int i = 0; i < width; i++) begin
         step(msb ? wv[width-1-i] : wv[i]);
         if (vld0_first && i == 0) chk("vld_clear", 32'(o_vld), 32'h0);
         if (act_chk) chk("active", 32'(o_act), (i == width - 1) ? 32'(act_last) : 32'(act_mid));
         if (i == width - 1 && exp_word) begin
            chk("word_stb", 32'(o_stb), 32'h1);
            e = exp_q.pop_front();
            chk("word_data", 32'(o_data), 32'(e.d));
            chk("word_vld", 32'(o_vld), 32'(e.v));
         end else begin
            chk("stb_idle", 32'(o_stb), 32'h0);
         end
      end
   endtask

   task automatic lock_seq(input logic [9:0] comma);
      for (int k = 0; k < 3; k++) send_word(comma, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(comma, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      // 1: defaults, lock on 32nd bit, first word 8 cycles later
      sel = 0;
      do_reset();
      lock_seq(10'h0BC);
      send_word(10'h05A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // 2: arbitrary offset
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'($urandom_range(0, 1)));
         chk("stb_prelock", 32'(o_stb), 32'h0);
      end
      lock_seq(10'h0BC);
      send_word(10'h033, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // 3: broken comma run then a full run
      do_reset();
      for (int k = 0; k < 3; k++) send_word(10'h0BC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      lock_seq(10'h0BC);

      // 4: locked stream with a comma in between
      send_word(10'h011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      send_word(10'h0BC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      send_word(10'h022, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // 5: loss of lock after four comma-free words, then relock
      sel = 1;
      do_reset();
      lock_seq(10'h0BC);
      send_word(10'h001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      send_word(10'h002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      send_word(10'h003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      send_word(10'h004, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      send_word(10'h0BC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) send_word(10'h0BC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(10'h0BC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_word(10'h07E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // 6: reset in the middle of confirmation
      sel = 0;
      do_reset();
      for (int k = 0; k < 2; k++) send_word(10'h0BC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      lock_seq(10'h0BC);
      send_word(10'h05A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // 6b: 10-bit comma, LSB first
      sel = 2;
      do_reset();
      lock_seq(10'h17C);
      send_word(10'h2A5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      send_word(10'h17C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
